// File: rtl/memstream_loader_pkg.sv
// Shared types and constants for the memstream weight loader.
package memstream_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_ADDR,
    S_LEN,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/memstream_loader.sv
// AXI-Stream frame loader writing {base, N, data...} frames into a memstream config port.
// Optional data checksum on csum when MEMSTREAM_LOADER_CSUM_EN is defined.
module memstream_loader
  import memstream_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 13824,
  parameter int unsigned MAX_LEN   = 65536
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [WORD_W-1:0] config_address,
  output logic              config_ce,
  output logic              config_we,
  output logic [WORD_W-1:0] config_d0,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] words_written,
  output logic [WORD_W-1:0] csum
);

  localparam logic [WORD_W-1:0] DEPTH_W   = WORD_W'(MEM_DEPTH);
  localparam logic [WORD_W-1:0] MAX_LEN_W = WORD_W'(MAX_LEN);

  state_e            state_q, state_nxt;
  logic              ready_q;
  logic              err_q;
  logic              err_set, err_clr;
  logic [WORD_W-1:0] base_q;
  logic [WORD_W-1:0] idx_q;
  logic [WORD_W-1:0] rem_q;
  logic [WORD_W-1:0] words_q;

  logic              acc_p0;
  logic              addr_beat_p0;
  logic [WORD_W-1:0] wr_addr_p0;
  logic              in_range_p0;
  logic              wr_vld_p0;

  logic              vld_p1;
  logic [WORD_W-1:0] addr_p1;
  logic [WORD_W-1:0] data_p1;

  // ---- stage p0: beat acceptance and write address decode ----
  assign acc_p0       = s_axis_tvalid && ready_q;
  assign addr_beat_p0 = acc_p0 && (state_q == S_ADDR);
  assign wr_addr_p0   = base_q + idx_q;
  assign in_range_p0  = (wr_addr_p0 < DEPTH_W);
  assign wr_vld_p0    = acc_p0 && (state_q == S_DATA) && in_range_p0;

  always_comb begin
    state_nxt = state_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state_q)
      S_ADDR: begin
        if (acc_p0) begin
          err_clr = 1'b1;
          if (s_axis_tlast) err_set = 1'b1;
          else              state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (acc_p0) begin
          if (s_axis_tdata > MAX_LEN_W) begin
            err_set   = 1'b1;
            state_nxt = s_axis_tlast ? S_ADDR : S_DRAIN;
          end else if (s_axis_tdata == '0) begin
            if (s_axis_tlast) begin
              state_nxt = S_DONE;
            end else begin
              err_set   = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (s_axis_tlast) begin
            err_set   = 1'b1;
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc_p0) begin
          if (!in_range_p0) err_set = 1'b1;
          if (rem_q == WORD_W'(1)) begin
            if (!s_axis_tlast) begin
              err_set   = 1'b1;
              state_nxt = S_DRAIN;
            end else if (err_q || !in_range_p0) begin
              // A frame that hit a suppressed write never reports done.
              state_nxt = S_ADDR;
            end else begin
              state_nxt = S_DONE;
            end
          end else if (s_axis_tlast) begin
            err_set   = 1'b1;
            state_nxt = S_ADDR;
          end
        end
      end
      S_DRAIN: begin
        if (acc_p0 && s_axis_tlast) state_nxt = S_ADDR;
      end
      S_DONE: begin
        state_nxt = S_ADDR;
      end
      default: begin
        state_nxt = S_ADDR;
      end
    endcase
  end

  // tready is registered from the next state so it drops exactly for S_DONE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_ADDR;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt != S_DONE);
      err_q   <= (err_q && !err_clr) || err_set;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_q <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else if (acc_p0) begin
      case (state_q)
        S_ADDR: base_q <= s_axis_tdata;
        S_LEN: begin
          rem_q <= s_axis_tdata;
          idx_q <= '0;
        end
        S_DATA: begin
          idx_q <= idx_q + WORD_W'(1);
          rem_q <= rem_q - WORD_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered memory write port ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_vld_p0;
      if (wr_vld_p0) begin
        addr_p1 <= wr_addr_p0;
        data_p1 <= s_axis_tdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)          words_q <= '0;
    else if (addr_beat_p0) words_q <= '0;
    else if (wr_vld_p0)    words_q <= words_q + WORD_W'(1);
  end

`ifdef MEMSTREAM_LOADER_CSUM_EN
  logic [WORD_W-1:0] csum_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)          csum_q <= '0;
    else if (addr_beat_p0) csum_q <= '0;
    else if (wr_vld_p0)    csum_q <= csum_q + s_axis_tdata;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

  assign s_axis_tready  = ready_q;
  assign config_address = addr_p1;
  assign config_d0      = data_p1;
  assign config_ce      = vld_p1;
  assign config_we      = vld_p1;
  assign busy           = (state_q != S_ADDR);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_memstream_loader.sv
// Randomized bench for memstream_loader against a frame-level reference model.
module tb_memstream_loader;

  localparam int unsigned MEM_DEPTH = 13824;
  localparam int unsigned MAX_LEN   = 65536;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] config_address;
  logic        config_ce;
  logic        config_we;
  logic [31:0] config_d0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_written;
  logic [31:0] csum;

  memstream_loader #(
    .MEM_DEPTH(MEM_DEPTH),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .config_address(config_address),
    .config_ce     (config_ce),
    .config_we     (config_we),
    .config_d0     (config_d0),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written),
    .csum          (csum)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: observes the config port away from the active edge.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_ce_cnt = 0;
  int          we_bad = 0;
  logic [31:0] done_addr = '0;

  always @(negedge aclk) begin
    cyc++;
    if (config_ce) begin
      wq_addr.push_back(config_address);
      wq_data.push_back(config_d0);
      wq_cyc.push_back(cyc);
    end
    if (config_ce !== config_we) we_bad++;
    if (done) begin
      done_cnt++;
      if (config_ce) begin
        done_ce_cnt++;
        done_addr = config_address;
      end
    end
  end

  // Frame under test ({tlast, data} per beat) and its expected outcome.
  logic [32:0] frm[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_err;
  bit          exp_done;

  task automatic build_frame(input logic [31:0] base, input logic [31:0] n, input int ndata);
    frm.delete();
    frm.push_back({1'b0, base});
    frm.push_back({(ndata == 0), n});
    for (int i = 0; i < ndata; i++) frm.push_back({(i == ndata - 1), $urandom()});
  endtask

  task automatic model_frame();
    logic [31:0] base, n, addr;
    int p;
    exp_a.delete();
    exp_d.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (frm[0][32]) begin
      exp_err = 1'b1;
      return;
    end
    base = frm[0][31:0];
    n    = frm[1][31:0];
    if (n > MAX_LEN) begin
      exp_err = 1'b1;
      return;
    end
    if (n == 0) begin
      exp_done = frm[1][32];
      exp_err  = !frm[1][32];
      return;
    end
    if (frm[1][32]) begin
      exp_err = 1'b1;
      return;
    end
    p = -1;
    for (int i = 2; i < frm.size(); i++) begin
      if (frm[i][32]) begin
        p = i - 2;
        break;
      end
    end
    for (int k = 0; k <= p && k < int'(n); k++) begin
      addr = base + k;
      if (addr < MEM_DEPTH) begin
        exp_a.push_back(addr);
        exp_d.push_back(frm[k + 2][31:0]);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (p != int'(n) - 1) exp_err = 1'b1;
    exp_done = !exp_err;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input int gap_pct,
                           inout int stalls);
    int waits;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
    end
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    waits = 0;
    while (!s_axis_tready) begin
      stalls++;
      waits++;
      if (waits >= 50) begin
        chk("tready_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".done"},   32'(done), 32'd0);
    chk({tag, ".err"},    32'(err), 32'd0);
    chk({tag, ".ce"},     32'(config_ce), 32'd0);
    chk({tag, ".we"},     32'(config_we), 32'd0);
    chk({tag, ".addr"},   config_address, 32'd0);
    chk({tag, ".d0"},     config_d0, 32'd0);
    chk({tag, ".ww"},     words_written, 32'd0);
    chk({tag, ".csum"},   csum, 32'd0);
  endtask

  task automatic run_frame(input string tag, input int gap_pct);
    int w0, dc0, dce0, stalls, nw;
    logic [31:0] sum;
    model_frame();
    w0     = wq_addr.size();
    dc0    = done_cnt;
    dce0   = done_ce_cnt;
    stalls = 0;
    foreach (frm[i]) send_beat(frm[i][31:0], frm[i][32], gap_pct, stalls);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (4) @(negedge aclk);
    nw  = wq_addr.size() - w0;
    sum = '0;
    foreach (exp_d[i]) sum = sum + exp_d[i];
    chk({tag, ".nwr"}, nw, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < nw; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), wq_addr[w0 + i], exp_a[i]);
      chk($sformatf("%s.data%0d", tag, i), wq_data[w0 + i], exp_d[i]);
    end
    chk({tag, ".err"},    32'(err), 32'(exp_err));
    chk({tag, ".ndone"},  done_cnt - dc0, 32'(exp_done));
    chk({tag, ".ww"},     words_written, exp_a.size());
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".stalls"}, stalls, 32'd0);
`ifdef MEMSTREAM_LOADER_CSUM_EN
    chk({tag, ".csum"},   csum, sum);
`else
    chk({tag, ".csum"},   csum, 32'd0);
`endif
    if (exp_done && exp_a.size() > 0) begin
      chk({tag, ".done_ce"},   done_ce_cnt - dce0, 32'd1);
      chk({tag, ".done_addr"}, done_addr, exp_a[exp_a.size() - 1]);
    end else begin
      chk({tag, ".done_ce"},   done_ce_cnt - dce0, 32'd0);
    end
    if (gap_pct == 0 && !exp_err && nw == exp_a.size() && nw > 1)
      chk({tag, ".contig"}, wq_cyc[w0 + nw - 1] - wq_cyc[w0], nw - 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n, nd, w0, stalls;
    logic [31:0] base;

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge aclk);
    check_zero("reset");
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);

    build_frame(32'h10, 32'd3, 3);                run_frame("basic", 0);
    build_frame(MEM_DEPTH - 1, 32'd2, 2);         run_frame("edge", 0);
    build_frame(32'h0, 32'd4, 2);                 run_frame("short", 0);
    build_frame(32'h20, 32'd2, 2);                run_frame("after_short", 0);
    build_frame(32'h0, 32'd2, 4);                 run_frame("long", 0);
    build_frame(32'h40, 32'd16, 16);              run_frame("gaps16", 50);
    build_frame(32'hFFFF_FFFE, 32'd4, 4);         run_frame("wrap", 0);
    build_frame(32'h5, 32'd0, 0);                 run_frame("len0_last", 0);
    build_frame(32'h5, 32'd0, 2);                 run_frame("len0_data", 0);
    build_frame(32'h5, MAX_LEN + 1, 3);           run_frame("len_big", 0);
    build_frame(32'h5, MAX_LEN + 1, 0);           run_frame("len_big_last", 0);
    build_frame(32'h5, MAX_LEN, 2);               run_frame("len_max", 0);
    build_frame(32'h7, 32'd3, 0);                 run_frame("len_last", 0);
    frm.delete(); frm.push_back({1'b1, 32'h9});   run_frame("addr_last", 0);

    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin n = $urandom_range(1, 12); base = $urandom_range(0, MEM_DEPTH - 13); nd = n; end
        1: begin n = $urandom_range(1, 8); base = MEM_DEPTH - $urandom_range(1, 6); nd = n; end
        2: begin n = $urandom_range(3, 10); base = $urandom_range(0, 1000); nd = $urandom_range(1, n - 1); end
        3: begin n = $urandom_range(1, 5); base = $urandom_range(0, 1000); nd = n + $urandom_range(1, 3); end
        4: begin n = 0; base = $urandom_range(0, 1000); nd = $urandom_range(0, 2); end
        5: begin n = 1; base = $urandom_range(0, 1000); nd = 0; end
        default: begin n = 6; base = 32'hFFFF_FFFF - $urandom_range(0, 3); nd = n; end
      endcase
      build_frame(base, n, nd);
      if (kind == 5) begin
        frm.delete();
        frm.push_back({1'b1, base});
      end
      run_frame($sformatf("rnd%0d_k%0d", t, kind), 50);
    end

    // Reset during the sixth beat of a 10-word frame.
    build_frame(32'h100, 32'd10, 10);
    w0     = wq_addr.size();
    stalls = 0;
    for (int i = 0; i < 5; i++) send_beat(frm[i][31:0], frm[i][32], 0, stalls);
    @(negedge aclk);
    s_axis_tdata  = frm[5][31:0];
    s_axis_tlast  = frm[5][32];
    s_axis_tvalid = 1'b1;
    #2 aresetn = 1'b0;
    #1 check_zero("rst_mid");
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_mid.pre_writes", wq_addr.size() - w0, 32'd3);
    aresetn = 1'b1;
    repeat (6) @(negedge aclk);
    chk("rst_mid.post_writes", wq_addr.size() - w0, 32'd3);
    chk("rst_mid.stalls", stalls, 32'd0);
    build_frame(32'h200, 32'd5, 5);               run_frame("after_rst", 0);

    chk("ce_we_match", we_bad, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
